// File: rtl/spi_cmd_sequencer_if.sv
// Host command, SPI controller and response signals of the SPI command sequencer.
// The sequencer takes the slave modport; the host/controller side takes master.
interface spi_cmd_sequencer_if;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        cmd_ready;
  logic        spi_tx_start;
  logic [23:0] spi_tx_data;
  logic        spi_tx_end;
  logic [23:0] spi_rx_data;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic        rsp_src;

  modport slave (
    input  cmd_valid, cmd_data, spi_tx_end, spi_rx_data,
    output cmd_ready, spi_tx_start, spi_tx_data, rsp_valid, rsp_data, rsp_src
  );

  modport master (
    output cmd_valid, cmd_data, spi_tx_end, spi_rx_data,
    input  cmd_ready, spi_tx_start, spi_tx_data, rsp_valid, rsp_data, rsp_src
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Round-robin scheduler of host FIFO commands and periodic poll words onto one SPI master.
// One transaction at a time: grant, start pulse, wait for tx_end (or timeout), enforced gap.
module spi_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               fxclk,
  input  logic               reset_in,
  spi_cmd_sequencer_if.slave bus,
  input  logic               poll_en,
  input  logic [15:0]        poll_period,
  input  logic [23:0]        poll_word,
  output logic               busy,
  output logic [4:0]         fifo_level,
  output logic               timeout_err,
  input  logic               err_clr
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t state, state_n;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic          push, pop, host_req;
  logic [15:0]   ptimer;
  logic          poll_pending, poll_run, poll_expire;
  logic          last_grant, src, tx_end_q;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          grant, grant_poll, rise, tmo;

  assign push        = bus.cmd_valid && bus.cmd_ready;
  assign pop         = grant && !grant_poll;
  assign host_req    = (count != '0);
  assign count_n     = count + CW'(push) - CW'(pop);
  assign poll_run    = poll_en && (poll_period != 16'd0);
  // >= rather than == so a shrinking period cannot strand the timer above it
  assign poll_expire = poll_run && (ptimer >= poll_period - 16'd1);

  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    grant_poll = 1'b0;
    rise       = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: if (host_req || poll_pending) begin
        grant      = 1'b1;
        // last_grant: 1 = poll went last, so host wins a tie
        grant_poll = poll_pending && (!host_req || !last_grant);
        state_n    = START;
      end
      START: state_n = WAIT;
      WAIT: begin
        if (bus.spi_tx_end && !tx_end_q) begin
          rise    = 1'b1;
          state_n = GAP;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          state_n = GAP;
        end
      end
      GAP: if (gcnt == GW'(GAP_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge fxclk) begin
    if (push) mem[wptr] <= bus.cmd_data;
  end

  always_ff @(posedge fxclk) begin
    if (reset_in) begin
      state            <= IDLE;
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      ptimer           <= '0;
      poll_pending     <= 1'b0;
      last_grant       <= 1'b1;
      src              <= 1'b0;
      tx_end_q         <= 1'b0;
      tcnt             <= '0;
      gcnt             <= '0;
      bus.cmd_ready    <= 1'b1;
      bus.spi_tx_start <= 1'b0;
      bus.spi_tx_data  <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_src      <= 1'b0;
      busy             <= 1'b0;
      fifo_level       <= '0;
      timeout_err      <= 1'b0;
    end else begin
      state            <= state_n;
      tx_end_q         <= bus.spi_tx_end;
      bus.spi_tx_start <= (state == START);
      bus.rsp_valid    <= rise;
      busy             <= (state_n != IDLE);

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count         <= count_n;
      fifo_level    <= 5'(count_n);
      bus.cmd_ready <= (count_n < CW'(FIFO_DEPTH));

      if (grant) begin
        src             <= grant_poll;
        last_grant      <= grant_poll;
        bus.spi_tx_data <= grant_poll ? poll_word : mem[rptr];
      end
      if (rise) begin
        bus.rsp_data <= bus.spi_rx_data;
        bus.rsp_src  <= src;
      end

      if (state == WAIT) tcnt <= tcnt + 1'b1;
      else               tcnt <= '0;
      if (state == GAP)  gcnt <= gcnt + 1'b1;
      else               gcnt <= '0;

      if (tmo)          timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (!poll_run || poll_expire) ptimer <= '0;
      else                          ptimer <= ptimer + 16'd1;

      // an expiry while already pending is simply absorbed
      if (!poll_en)         poll_pending <= 1'b0;
      else if (poll_expire) poll_pending <= 1'b1;
      else if (grant_poll)  poll_pending <= 1'b0;
    end
  end
endmodule
